// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: machine word and the memory arbiter grant state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IGNT = 2'd1,
    ARB_DGNT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the arbiter's pipeline-side and RAM-side signals for reuse in wrappers and benches.
interface mem_arbiter_if
  import cpu_types_pkg::*;
(
  input logic CLK
);

  logic       nRST;
  logic       iREN;
  word_t      iaddr;
  logic       iwait;
  word_t      iload;
  logic       dREN;
  logic       dWEN;
  word_t      daddr;
  word_t      dstore;
  logic       dwait;
  word_t      dload;
  logic       ramREN;
  logic       ramWEN;
  word_t      ramaddr;
  word_t      ramstore;
  word_t      ramload;
  logic       ramrdy;
  arb_state_t gnt;

  modport arb (
    input  CLK, nRST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramrdy,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, gnt
  );

  modport tb (
    input  CLK, iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, gnt,
    output nRST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramrdy
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between fetch and data paths: data priority with a
// saturating streak counter that forces a fetch grant after STARVE_MAX data grants.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       iREN,
  input  word_t      iaddr,
  output logic       iwait,
  output word_t      iload,
  input  logic       dREN,
  input  logic       dWEN,
  input  word_t      daddr,
  input  word_t      dstore,
  output logic       dwait,
  output word_t      dload,
  output logic       ramREN,
  output logic       ramWEN,
  output word_t      ramaddr,
  output word_t      ramstore,
  input  word_t      ramload,
  input  logic       ramrdy,
  output arb_state_t gnt
);

  localparam int unsigned   SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STREAK_SAT = SW'(STARVE_MAX);

  arb_state_t    state_q, state_d;
  logic [SW-1:0] dstreak_q, dstreak_d;
  logic          dreq;

  assign dreq = dREN | dWEN;
  assign gnt  = state_q;

  always_comb begin
    state_d   = ARB_IDLE;
    dstreak_d = dstreak_q;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    iwait     = 1'b1;
    iload     = '0;
    dwait     = 1'b1;
    dload     = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (dreq && !(iREN && dstreak_q == STREAK_SAT)) state_d = ARB_DGNT;
        else if (iREN)                                  state_d = ARB_IGNT;
      end
      // A withdrawn request falls through with all outputs idle: that is the abort path.
      ARB_IGNT: begin
        if (iREN) begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ramrdy) begin
            iwait     = 1'b0;
            iload     = ramload;
            dstreak_d = '0;
          end else begin
            state_d = ARB_IGNT;
          end
        end
      end
      ARB_DGNT: begin
        if (dreq) begin
          ramaddr = daddr;
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          if (ramrdy) begin
            dwait = 1'b0;
            dload = dWEN ? '0 : ramload;
            if (!iREN)                        dstreak_d = '0;
            else if (dstreak_q != STREAK_SAT) dstreak_d = dstreak_q + SW'(1);
          end else begin
            state_d = ARB_DGNT;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= ARB_IDLE;
      dstreak_q <= '0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the grant rules.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int SMAX = 2;

  logic       CLK;
  logic       nRST;
  logic       iREN;
  word_t      iaddr;
  logic       iwait;
  word_t      iload;
  logic       dREN;
  logic       dWEN;
  word_t      daddr;
  word_t      dstore;
  logic       dwait;
  word_t      dload;
  logic       ramREN;
  logic       ramWEN;
  word_t      ramaddr;
  word_t      ramstore;
  word_t      ramload;
  logic       ramrdy;
  arb_state_t gnt;

  mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramrdy(ramrdy), .gnt(gnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Model: who owns the RAM (0 nobody, 1 fetch, 2 data) and how many data grants
  // have been served back-to-back while a fetch was waiting.
  int owner = 0;
  int streak = 0;
  int nxt_owner = 0;
  int nxt_streak = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    logic [31:0] e_rren, e_rwen, e_addr, e_store, e_iwait, e_dwait, e_iload, e_dload;
    logic        want_d;
    @(negedge CLK);
    e_rren = 0; e_rwen = 0; e_addr = 0; e_store = 0;
    e_iwait = 1; e_dwait = 1; e_iload = 0; e_dload = 0;
    want_d = dREN | dWEN;
    nxt_owner  = 0;
    nxt_streak = streak;
    if (owner == 0) begin
      if (want_d && !(iREN && streak == SMAX)) nxt_owner = 2;
      else if (iREN)                           nxt_owner = 1;
    end else if (owner == 1 && iREN) begin
      e_rren = 1;
      e_addr = iaddr;
      if (ramrdy) begin
        e_iwait = 0; e_iload = ramload; nxt_streak = 0;
      end else nxt_owner = 1;
    end else if (owner == 2 && want_d) begin
      e_addr = daddr;
      if (dWEN) begin e_rwen = 1; e_store = dstore; end
      else e_rren = 1;
      if (ramrdy) begin
        e_dwait = 0;
        e_dload = dWEN ? 32'h0 : ramload;
        nxt_streak = iREN ? ((streak + 1 > SMAX) ? SMAX : streak + 1) : 0;
      end else nxt_owner = 2;
    end
    if (!nRST) begin nxt_owner = 0; nxt_streak = 0; end
    chk("gnt",      32'(gnt),    32'(owner));
    chk("ramREN",   32'(ramREN), e_rren);
    chk("ramWEN",   32'(ramWEN), e_rwen);
    chk("ramaddr",  ramaddr,     e_addr);
    chk("ramstore", ramstore,    e_store);
    chk("iwait",    32'(iwait),  e_iwait);
    chk("dwait",    32'(dwait),  e_dwait);
    chk("iload",    iload,       e_iload);
    chk("dload",    dload,       e_dload);
  endtask

  task automatic advance();
    @(posedge CLK);
    #1;
    owner  = nxt_owner;
    streak = nxt_streak;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  arb_state_t order [6] = '{ARB_DGNT, ARB_DGNT, ARB_IGNT, ARB_DGNT, ARB_DGNT, ARB_IGNT};
  int ngrant;

  initial begin
    nRST = 1'b0; iREN = 1'b1; dWEN = 1'b1; dREN = 1'b0; ramrdy = 1'b1;
    iaddr = '0; daddr = '0; dstore = '0; ramload = 32'h1111_2222;

    // Reset held with both requesters active and the RAM claiming ready.
    advance();
    advance();
    settle();
    chk("rst_gnt",    32'(gnt),    32'(ARB_IDLE));
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_iwait",  32'(iwait),  32'd1);
    advance();
    nRST = 1'b1;
    settle();
    chk("rel_gnt_idle", 32'(gnt), 32'(ARB_IDLE));
    advance();
    settle();
    chk("rel_gnt_d", 32'(gnt), 32'(ARB_DGNT));
    advance();
    iREN = 1'b0; dWEN = 1'b0; ramrdy = 1'b0;
    step();

    // Lone fetch with two RAM wait cycles.
    iREN = 1'b1; iaddr = 32'h40;
    settle();
    chk("lf_c0_gnt", 32'(gnt), 32'(ARB_IDLE));
    advance();
    for (int c = 1; c <= 2; c++) begin
      settle();
      chk("lf_ramREN",  32'(ramREN), 32'd1);
      chk("lf_ramaddr", ramaddr,     32'h40);
      chk("lf_iwait_w", 32'(iwait),  32'd1);
      advance();
    end
    ramrdy = 1'b1; ramload = 32'hDEAD_BEEF;
    settle();
    chk("lf_iwait", 32'(iwait), 32'd0);
    chk("lf_iload", iload,      32'hDEAD_BEEF);
    advance();
    iREN = 1'b0; ramrdy = 1'b0;
    settle();
    chk("lf_c4_gnt",    32'(gnt),    32'(ARB_IDLE));
    chk("lf_c4_ramREN", 32'(ramREN), 32'd0);
    advance();

    // Contention: data write wins, fetch follows after the turnaround.
    iREN = 1'b1; iaddr = 32'h100; dWEN = 1'b1; daddr = 32'h200; dstore = 32'h1234; ramrdy = 1'b1;
    step();
    settle();
    chk("ct_ramWEN",   32'(ramWEN), 32'd1);
    chk("ct_ramaddr",  ramaddr,     32'h200);
    chk("ct_ramstore", ramstore,    32'h1234);
    chk("ct_dwait",    32'(dwait),  32'd0);
    chk("ct_dload",    dload,       32'd0);
    advance();
    dWEN = 1'b0;
    settle();
    chk("ct_c2_gnt", 32'(gnt), 32'(ARB_IDLE));
    advance();
    settle();
    chk("ct_ramREN",  32'(ramREN), 32'd1);
    chk("ct_ramaddr_i", ramaddr,   32'h100);
    chk("ct_iwait",   32'(iwait),  32'd0);
    advance();
    iREN = 1'b0; ramrdy = 1'b0;
    step();

    // Starvation bound: grant order with both sides held high.
    dREN = 1'b1; iREN = 1'b1; ramrdy = 1'b1; daddr = 32'h500; iaddr = 32'h600;
    ngrant = 0;
    for (int c = 0; c < 12; c++) begin
      settle();
      if (gnt != ARB_IDLE && ngrant < 6) begin
        chk("starve_order", 32'(gnt), 32'(order[ngrant]));
        ngrant++;
      end
      advance();
    end
    chk("starve_count", 32'(ngrant), 32'd6);
    dREN = 1'b0; iREN = 1'b0; ramrdy = 1'b0;
    step();

    // Abort of a granted fetch, then a normal data read.
    iREN = 1'b1; iaddr = 32'h80;
    step();
    settle();
    chk("ab_ramREN_on", 32'(ramREN), 32'd1);
    advance();
    iREN = 1'b0;
    settle();
    chk("ab_ramREN_off", 32'(ramREN), 32'd0);
    chk("ab_iwait",      32'(iwait),  32'd1);
    advance();
    dREN = 1'b1; daddr = 32'h300; ramrdy = 1'b1; ramload = 32'hCAFE_F00D;
    settle();
    chk("ab_gnt_idle", 32'(gnt), 32'(ARB_IDLE));
    advance();
    settle();
    chk("ab_dwait", 32'(dwait), 32'd0);
    chk("ab_dload", dload,      32'hCAFE_F00D);
    advance();
    dREN = 1'b0; ramrdy = 1'b0;
    step();

    // Saturate the streak, then reset during a stalled write: the streak must clear.
    iREN = 1'b1; dREN = 1'b1; ramrdy = 1'b1;
    repeat (4) step();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b1; daddr = 32'h400; dstore = 32'h55AA; ramrdy = 1'b0;
    step();
    nRST = 1'b0;
    settle();
    chk("rw_gnt_d",  32'(gnt),    32'(ARB_DGNT));
    chk("rw_ramWEN", 32'(ramWEN), 32'd1);
    advance();
    nRST = 1'b1; iREN = 1'b1;
    settle();
    chk("rw_ramWEN_off", 32'(ramWEN), 32'd0);
    chk("rw_dwait",      32'(dwait),  32'd1);
    chk("rw_gnt_idle",   32'(gnt),    32'(ARB_IDLE));
    advance();
    settle();
    chk("rw_streak_clr", 32'(gnt), 32'(ARB_DGNT));
    advance();
    iREN = 1'b0; dWEN = 1'b0;
    step();
    step();

    // Random traffic, including mid-access withdrawals.
    repeat (400) begin
      iREN    = ($urandom_range(0, 3) != 0);
      dREN    = ($urandom_range(0, 1) != 0);
      dWEN    = ($urandom_range(0, 3) == 0);
      ramrdy  = ($urandom_range(0, 1) != 0);
      iaddr   = $urandom;
      daddr   = $urandom;
      dstore  = $urandom;
      ramload = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter sharing the single-port unified RAM between the instruction fetch path and the data path of the 5-stage pipeline. It grants one requester at a time through a small FSM and holds the grant until the RAM reports completion or the requester withdraws. Data requests have priority over fetches, and a bounded starvation counter guarantees forward progress for fetch. Its `iwait`/`dwait` outputs feed the hazard unit's `ihit`/`dhit` (hit = !wait).

## Interface
- `STARVE_MAX`, default 4: consecutive data grants allowed while a fetch is pending; legal range ≥1.
- `CLK`  in  1  system clock, rising edge.
- `nRST`  in  1  synchronous, active-low reset.
- `iREN`  in  1  instruction read request.
- `iaddr`  in  32 (`word_t`)  fetch address.
- `iwait`  out  1  low for exactly the completion cycle of a fetch.
- `iload`  out  32  fetched word; valid when `iwait`=0, otherwise 0.
- `dREN`  in  1  data read request.
- `dWEN`  in  1  data write request; takes precedence if asserted together with `dREN`.
- `daddr`  in  32  data address.
- `dstore`  in  32  write data.
- `dwait`  out  1  low for exactly the completion cycle of a data access.
- `dload`  out  32  read data; valid when `dwait`=0 on a read, otherwise 0.
- `ramREN`, `ramWEN`  out  1 each  RAM strobes.
- `ramaddr`  out  32  RAM address.
- `ramstore`  out  32  RAM write data.
- `ramload`  in  32  RAM read data.
- `ramrdy`  in  1  RAM access completes this cycle.
- `gnt`  out  2 (`arb_state_t`)  current FSM state, for debug and the hazard unit.

## Operation
- States: `ARB_IDLE`, `ARB_IGNT`, `ARB_DGNT`. Reset enters `ARB_IDLE` and clears `dstreak`.
- IDLE:
  - data request (`dREN|dWEN`) and !(`iREN` && `dstreak`==`STARVE_MAX`) → `ARB_DGNT`;
  - else `iREN` → `ARB_IGNT`;
  - else stay.
  - All RAM outputs are 0.
- IGNT:
  - `ramREN`=1, `ramaddr`=`iaddr` (combinational pass-through).
  - `ramrdy` && `iREN` → `iwait`=0, `iload`=`ramload`, next `ARB_IDLE`, `dstreak`←0.
- DGNT:
  - `ramaddr`=`daddr`. `dWEN` → `ramWEN`=1 and `ramstore`=`dstore`; else `ramREN`=1.
  - `ramrdy` && (`dREN|dWEN`) → `dwait`=0, `dload`=`ramload` on a read (0 on a write), next `ARB_IDLE`.
  - On that completion, `dstreak`←min(`dstreak`+1, `STARVE_MAX`) if `iREN`=1, else `dstreak`←0.
- Abort: if the granted requester's request is low in a GNT state, that cycle drives no RAM strobe, reports no completion, and the next state is IDLE. `dstreak` is unchanged. This covers flush-dropped fetches.
- `iwait`/`dwait` are 1 in every cycle that is not a completion cycle of that side.
- Writes never report data on `dload`.

## Timing
- Reset (`nRST`=0 at an edge): next cycle `gnt`=IDLE, `dstreak`=0. All outputs then read: `ramREN`=`ramWEN`=0, `ramaddr`=`ramstore`=0, `iwait`=`dwait`=1, `iload`=`dload`=0.
- Reset mid-access: the access is dropped with no completion pulse, and the RAM strobes are low the cycle after the reset edge.
- Request latency:
  - request first seen in IDLE at cycle n → grant state at n+1;
  - `ramrdy` at n+1 gives completion at n+1 (minimum 2 cycles, request to hit);
  - each RAM wait cycle adds one cycle.
- A one-cycle IDLE turnaround is mandatory after every completion or abort, so back-to-back accesses are spaced at least 2 cycles apart.
- Completion outputs are combinational from state, `ramrdy` and `ramload`. No registered data path.
- `ramrdy` in IDLE is ignored.
- Simultaneous `iREN` and data request in IDLE: data wins unless `dstreak`==`STARVE_MAX`.

## Structure
- Add `arb_state_t` (enum logic [1:0]: `ARB_IDLE`=0, `ARB_IGNT`=1, `ARB_DGNT`=2) to `cpu_types_pkg`.
- Add a `mem_arbiter_if` interface with an `arb` modport and a `tb` modport.
- `dstreak` is a `$clog2(STARVE_MAX+1)`-bit saturating counter.
- Flat module. No sub-module is warranted.

## Test plan
- Reset: hold `nRST`=0 with `iREN`=`dWEN`=1 and `ramrdy`=1 → strobes 0, `iwait`=`dwait`=1, `gnt`=IDLE. The first grant is seen the cycle after release + 1.
- Lone fetch: `iREN`=1, `iaddr`=0x40 at cycle 0; `ramrdy` at cycle 3 with `ramload`=0xDEADBEEF → `ramREN`=1 and `ramaddr`=0x40 for cycles 1–3. `iwait`=0 and `iload`=0xDEADBEEF only at cycle 3; cycle 4 is IDLE with `ramREN`=0.
- Contention: `iREN` with `iaddr`=0x100, plus `dWEN` with `daddr`=0x200 and `dstore`=0x1234, `ramrdy`=1 → cycle 1 `ramWEN`=1, `ramaddr`=0x200, `ramstore`=0x1234, `dwait`=0; cycle 2 IDLE; cycle 3 `ramREN`=1, `ramaddr`=0x100, `iwait`=0.
- Starvation: `STARVE_MAX`=2, `dREN` and `iREN` held high, `ramrdy`=1 → grant order D, D, I, D, D, I.
- Abort: fetch granted at 0x80, `ramrdy`=0; drop `iREN` at cycle 2 → `ramREN`=0 in cycle 2, no `iwait` pulse, IDLE at cycle 3. A later `dREN` is served normally.
- Reset mid-write: `nRST`=0 during DGNT with `ramrdy`=0 → `ramWEN`=0 the next cycle, `dwait` stays 1, `dstreak`=0.
